// File: rtl/toksync_gen.sv
// toksync_gen: builds timestamped trigger blocks from qualifying tokens.
// A running GTIME counter is snapshotted when a token starts a block.
// The block is streamed to a FIFO one 16-bit word per cycle, honouring
// the FIFO's full flag. The stream is: header, type/parity/missed/token,
// then the captured time in 15-bit slices, least significant slice first.
module toksync_gen #(
  parameter int         TW    = 45,
  parameter logic [2:0] BTYPE = 3'd5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [9:0]  i_token,
  input  logic        i_tok_rdy,
  input  logic [3:0]  i_tok_div,
  input  logic        i_inhibit,
  input  logic        i_enable,
  input  logic        i_tok_full,
  output logic [15:0] o_tok_dat,
  output logic        o_tok_vld
);

  localparam int             NW     = TW / 15;
  localparam int             CW     = 4;
  localparam logic [CW-1:0]  LAST   = CW'(NW + 1);
  localparam logic [15:0]    HEADER = {7'b1000000, 9'(NW + 1)};

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_gtime;
  logic [TW-1:0]   r_gtimes;
  logic [9:0]      r_tok;
  logic            r_p;
  logic            r_m;

  logic [3:0]      w_div;
  logic [10:0]     w_mask;
  logic            w_qual;
  logic            w_trig;
  logic [15:0]     w_word;

  // A divisor above 10 would look past the token width, so it saturates.
  // A divisor of 10 makes only token 0 qualify.
  assign w_div  = (i_tok_div > 4'd10) ? 4'd10 : i_tok_div;
  assign w_mask = (11'd1 << w_div) - 11'd1;
  assign w_qual = ((i_token & w_mask[9:0]) == 10'd0);
  assign w_trig = i_tok_rdy & i_enable & w_qual;

  // Select the word addressed by the counter while a block is being sent.
  always_comb begin
    w_word = 16'h0000;
    if (r_cnt == CW'(1)) begin
      w_word = {1'b0, BTYPE, r_p, r_m, r_tok};
    end
    for (int k = 0; k < NW; k++) begin
      if (r_cnt == CW'(k + 2)) begin
        w_word = {1'b0, r_gtimes[15*k +: 15]};
      end
    end
  end

  // Free-running time base, held at zero while inhibited.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gtime <= '0;
    end else if (i_inhibit) begin
      r_gtime <= '0;
    end else begin
      r_gtime <= r_gtime + TW'(1);
    end
  end

  // Block sequencer: captures a token, streams the words, and tracks parity and missed tokens.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_gtimes  <= '0;
      r_tok     <= '0;
      r_p       <= 1'b0;
      r_m       <= 1'b0;
      o_tok_dat <= 16'h0000;
      o_tok_vld <= 1'b0;
    end else if (i_inhibit) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_p       <= 1'b0;
      r_m       <= 1'b0;
      o_tok_vld <= 1'b0;
    end else begin
      o_tok_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            if (!i_tok_full) begin
              r_gtimes  <= r_gtime;
              r_tok     <= i_token;
              o_tok_dat <= HEADER;
              o_tok_vld <= 1'b1;
              r_cnt     <= CW'(1);
              r_state   <= SEND;
            end else begin
              r_m <= 1'b1;
            end
          end
        end
        SEND: begin
          if (!i_tok_full) begin
            o_tok_dat <= w_word;
            o_tok_vld <= 1'b1;
            if (r_cnt == LAST) begin
              r_p     <= ~r_p;
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          // A drop in the same cycle as the word-1 clear must win.
          if (w_trig) begin
            r_m <= 1'b1;
          end else if (!i_tok_full && r_cnt == CW'(1)) begin
            r_m <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
